// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and helpers for the writeback port arbiter.
package wb_port_arbiter_pkg;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_PRIO = 2'd1,
    GRANT_RR   = 2'd2
  } grant_kind_e;

  // Index following k in round-robin order, never landing on the priority unit.
  function automatic int unsigned next_rr_index(input int unsigned k,
                                                input int unsigned prio,
                                                input int unsigned n);
    int unsigned nxt;
    nxt = (k + 1) % n;
    if (nxt == prio) nxt = (nxt + 1) % n;
    return nxt;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_rr_grant_encoder.sv
// Round-robin grant encoder: first request at or after ptr (wrapping), ignoring SKIP_IDX.
module wb_port_arbiter_rr_grant_encoder
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_UNITS = 4,
  parameter int unsigned SKIP_IDX  = 0,
  parameter int unsigned PTR_W     = 2
) (
  input  logic [NUM_UNITS-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic [NUM_UNITS-1:0] grant,
  output logic [PTR_W-1:0]     next_ptr
);

  int unsigned      idx_u;
  logic [PTR_W-1:0] idx;

  // Scan from the farthest offset down so the nearest request wins by overwrite.
  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    idx_u    = 0;
    idx      = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      idx_u = (32'(ptr) + NUM_UNITS - 1 - i) % NUM_UNITS;
      idx   = PTR_W'(idx_u);
      if (idx_u != SKIP_IDX && req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        next_ptr   = PTR_W'(next_rr_index(idx_u, SKIP_IDX, NUM_UNITS));
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: fixed-priority unit plus round-robin, registered commit packet.
// Optional starvation guard enabled by defining WB_ARB_STARVATION_GUARD_EN.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_UNITS     = 4,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned PHYS_ADDR_W   = 6,
  parameter int unsigned ID_W          = 3,
  parameter int unsigned PRIORITY_UNIT = 0,
  parameter int unsigned MAX_WAIT      = 15
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   init_clear,
  input  logic                                   writeback_suppress,
  input  logic [NUM_UNITS-1:0]                   unit_done,
  input  logic [NUM_UNITS-1:0][PHYS_ADDR_W-1:0]  unit_phys_addr,
  input  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]   unit_data,
  input  logic [NUM_UNITS-1:0][ID_W-1:0]         unit_id,
  output logic [NUM_UNITS-1:0]                   unit_ack,
  output logic                                   commit_valid,
  output logic [PHYS_ADDR_W-1:0]                 commit_phys_addr,
  output logic [DATA_WIDTH-1:0]                  commit_data,
  output logic [ID_W-1:0]                        commit_id,
  output logic                                   inflight_clear
);

  localparam int unsigned PTR_W = $clog2(NUM_UNITS);

  typedef struct packed {
    logic [PHYS_ADDR_W-1:0] phys_addr;
    logic [DATA_WIDTH-1:0]  data;
    logic [ID_W-1:0]        id;
  } wb_request_t;

  typedef struct packed {
    logic                   valid;
    logic [PHYS_ADDR_W-1:0] phys_addr;
    logic [DATA_WIDTH-1:0]  data;
    logic [ID_W-1:0]        id;
  } commit_packet_t;

  if (NUM_UNITS < 2 || PRIORITY_UNIT >= NUM_UNITS || MAX_WAIT < 1) begin : g_bad_params
    $error("wb_port_arbiter: illegal parameter combination");
  end

  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     rr_next;
  logic [NUM_UNITS-1:0] rr_grant;
  logic                 starve_mask;
  grant_kind_e          grant_kind;
  wb_request_t          sel_req;
  commit_packet_t       commit_q;

  wb_port_arbiter_rr_grant_encoder #(
    .NUM_UNITS (NUM_UNITS),
    .SKIP_IDX  (PRIORITY_UNIT),
    .PTR_W     (PTR_W)
  ) u_rr_enc (
    .req      (unit_done),
    .ptr      (rr_ptr),
    .grant    (rr_grant),
    .next_ptr (rr_next)
  );

  // An ack during reset would be captured by nothing, so reset blocks grants too.
  always_comb begin
    unit_ack   = '0;
    grant_kind = GRANT_NONE;
    if (!rst && !init_clear) begin
      if (unit_done[PRIORITY_UNIT] && !starve_mask) begin
        unit_ack[PRIORITY_UNIT] = 1'b1;
        grant_kind              = GRANT_PRIO;
      end else if (|rr_grant) begin
        unit_ack   = rr_grant;
        grant_kind = GRANT_RR;
      end
    end
  end

  always_comb begin
    sel_req = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      if (unit_ack[i]) sel_req = '{phys_addr: unit_phys_addr[i], data: unit_data[i], id: unit_id[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= PTR_W'(next_rr_index(PRIORITY_UNIT, PRIORITY_UNIT, NUM_UNITS));
    end else if (grant_kind == GRANT_RR) begin
      rr_ptr <= rr_next;
    end
  end

  // Payload loads even on suppressed grants; only the valid strobe is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_q <= '0;
    end else begin
      commit_q.valid <= (grant_kind != GRANT_NONE) && !writeback_suppress;
      if (grant_kind != GRANT_NONE) begin
        commit_q.phys_addr <= sel_req.phys_addr;
        commit_q.data      <= sel_req.data;
        commit_q.id        <= sel_req.id;
      end
    end
  end

`ifdef WB_ARB_STARVATION_GUARD_EN
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  logic [NUM_UNITS-1:0][WAIT_W-1:0] wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_UNITS; i++) begin
        if (i == PRIORITY_UNIT || !unit_done[i] || unit_ack[i]) begin
          wait_cnt[i] <= '0;
        end else if (wait_cnt[i] != WAIT_W'(MAX_WAIT)) begin
          wait_cnt[i] <= wait_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    starve_mask = 1'b0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      if (i != PRIORITY_UNIT && wait_cnt[i] == WAIT_W'(MAX_WAIT)) starve_mask = 1'b1;
    end
  end
`else
  assign starve_mask = 1'b0;
`endif

  assign commit_valid     = commit_q.valid;
  assign commit_phys_addr = commit_q.phys_addr;
  assign commit_data      = commit_q.data;
  assign commit_id        = commit_q.id;
  assign inflight_clear   = commit_q.valid;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: spec-level model, per-cycle compare, directed and random vectors.
module tb_wb_port_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int IW = 3;
  localparam int P  = 0;
  localparam int MW = 15;
  localparam int W  = AW + DW + IW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                     init_clear = 1'b0;
  logic                     writeback_suppress = 1'b0;
  logic [N-1:0]             unit_done = '0;
  logic [N-1:0][AW-1:0]     unit_phys_addr = '0;
  logic [N-1:0][DW-1:0]     unit_data = '0;
  logic [N-1:0][IW-1:0]     unit_id = '0;
  logic [N-1:0]             unit_ack;
  logic                     commit_valid;
  logic [AW-1:0]            commit_phys_addr;
  logic [DW-1:0]            commit_data;
  logic [IW-1:0]            commit_id;
  logic                     inflight_clear;

  wb_port_arbiter #(
    .NUM_UNITS(N), .DATA_WIDTH(DW), .PHYS_ADDR_W(AW), .ID_W(IW),
    .PRIORITY_UNIT(P), .MAX_WAIT(MW)
  ) dut (
    .clk(clk), .rst(rst), .init_clear(init_clear), .writeback_suppress(writeback_suppress),
    .unit_done(unit_done), .unit_phys_addr(unit_phys_addr), .unit_data(unit_data),
    .unit_id(unit_id), .unit_ack(unit_ack), .commit_valid(commit_valid),
    .commit_phys_addr(commit_phys_addr), .commit_data(commit_data), .commit_id(commit_id),
    .inflight_clear(inflight_clear)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Valid handshake: a unit holds done+payload until ack is seen at a rising edge.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_hold;
  int           m_ptr;
  int           m_wait[N];
  int           m_g;

  function automatic int next_after(input int k);
    int x;
    x = (k + 1) % N;
    if (x == P) x = (x + 1) % N;
    return x;
  endfunction

  function automatic int exp_grant();
    bit starve;
    starve = 1'b0;
    if (rst || init_clear) return -1;
`ifdef WB_ARB_STARVATION_GUARD_EN
    for (int u = 0; u < N; u++) if (u != P && m_wait[u] >= MW) starve = 1'b1;
`endif
    if (unit_done[P] && !starve) return P;
    for (int k = 0; k < N; k++) begin
      if (((m_ptr + k) % N) != P && unit_done[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr  = next_after(P);
      m_hold = '0;
      for (int u = 0; u < N; u++) m_wait[u] = 0;
      exp_q.delete();
    end else begin
      m_g = exp_grant();
      for (int u = 0; u < N; u++) begin
        if (u == P || !unit_done[u] || u == m_g) m_wait[u] = 0;
        else if (m_wait[u] < MW) m_wait[u]++;
      end
      if (m_g >= 0) begin
        m_hold = {unit_phys_addr[m_g], unit_data[m_g], unit_id[m_g]};
        if (!writeback_suppress) exp_q.push_back(m_hold);
        if (m_g != P) m_ptr = next_after(m_g);
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [N-1:0] c_exp_ack;
  logic [W-1:0] c_pkt;
  logic         c_cv;
  int           c_g;

  always @(negedge clk) begin
    c_g = exp_grant();
    c_exp_ack = '0;
    if (c_g >= 0) c_exp_ack[c_g] = 1'b1;
    check("sb_unit_ack", unit_ack, c_exp_ack);
    c_cv  = (exp_q.size() != 0);
    c_pkt = c_cv ? exp_q.pop_front() : m_hold;
    check("sb_commit_valid", commit_valid, c_cv);
    check("sb_inflight_clear", inflight_clear, c_cv);
    check("sb_commit_addr", commit_phys_addr, c_pkt[W-1 -: AW]);
    check("sb_commit_data", commit_data, c_pkt[IW +: DW]);
    check("sb_commit_id", commit_id, c_pkt[IW-1:0]);
  end

  // ---------------- driver tasks ----------------
  task automatic set_unit(input int u, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [IW-1:0] id);
    unit_phys_addr[u] = a;
    unit_data[u]      = d;
    unit_id[u]        = id;
    unit_done[u]      = 1'b1;
  endtask

  task automatic step(input logic [N-1:0] exp_ack, input int exp_id, input bit retire);
    @(negedge clk);
    check("seq_ack", unit_ack, exp_ack);
    if (exp_id >= 0) check("seq_commit_id", commit_id, exp_id[IW-1:0]);
    @(posedge clk); #1;
    if (retire) unit_done = unit_done & ~exp_ack;
  endtask

  logic [N-1:0] acked;
  logic [N-1:0] sv_ack;

  initial begin
    // Reset with everything requesting.
    for (int u = 0; u < N; u++) set_unit(u, AW'(u + 1), 32'hA000_0000 + u, IW'(u));
    repeat (2) @(negedge clk);
    check("ack_in_reset", unit_ack, 4'b0000);
    check("cv_in_reset", commit_valid, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    step(4'b0001, -1, 1'b0);
    step(4'b0001, 0, 1'b0);
    step(4'b0001, 0, 1'b1);
    step(4'b0010, 0, 1'b1);
    step(4'b0100, 1, 1'b1);
    step(4'b1000, 2, 1'b1);
    step(4'b0000, 3, 1'b0);

    // Wrap-around from pointer 3 back to unit 1.
    set_unit(2, 6'd2, 32'hA000_0002, 3'd2);
    step(4'b0100, -1, 1'b1);
    set_unit(1, 6'd7, 32'h1111_0001, 3'd1);
    set_unit(3, 6'd9, 32'h3333_0003, 3'd3);
    step(4'b1000, 2, 1'b1);
    step(4'b0010, 3, 1'b1);
    step(4'b0000, 1, 1'b0);

    // Suppressed commit, then the same result committed.
    set_unit(2, 6'd5, 32'hDEAD_BEEF, 3'd6);
    writeback_suppress = 1'b1;
    @(negedge clk);
    check("sup_ack", unit_ack, 4'b0100);
    @(posedge clk); #1;
    unit_done = '0;
    writeback_suppress = 1'b0;
    @(negedge clk);
    check("sup_cv", commit_valid, 1'b0);
    check("sup_addr_loaded", commit_phys_addr, 6'd5);
    set_unit(2, 6'd5, 32'hDEAD_BEEF, 3'd6);
    @(posedge clk); #1 unit_done = '0;
    @(negedge clk);
    check("commit_cv", commit_valid, 1'b1);
    check("commit_addr", commit_phys_addr, 6'd5);
    check("commit_data", commit_data, 32'hDEAD_BEEF);
    check("commit_inflight", inflight_clear, 1'b1);

    // init_clear holds off every grant.
    @(posedge clk); #1;
    init_clear = 1'b1;
    for (int u = 0; u < N; u++) set_unit(u, AW'(u + 1), 32'hA000_0000 + u, IW'(u));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("init_ack", unit_ack, 4'b0000);
      check("init_cv", commit_valid, 1'b0);
    end
    @(posedge clk); #1 init_clear = 1'b0;
    step(4'b0001, -1, 1'b1);
    step(4'b1000, 0, 1'b1);
    step(4'b0010, 3, 1'b1);
    step(4'b0100, 1, 1'b1);

    // Priority unit requesting continuously against unit 1.
    set_unit(0, 6'd10, 32'h0000_00AA, 3'd0);
    set_unit(1, 6'd11, 32'h0000_00BB, 3'd1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
`ifdef WB_ARB_STARVATION_GUARD_EN
      sv_ack = (c == MW) ? 4'b0010 : 4'b0001;
`else
      sv_ack = 4'b0001;
`endif
      check("starve_ack", unit_ack, sv_ack);
      @(posedge clk); #1;
      unit_done = unit_done & ~(sv_ack & 4'b1110);
    end
    unit_done = '0;
    @(posedge clk); #1;

    // Random traffic under the handshake rules.
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      acked = unit_ack;
      @(posedge clk); #1;
      unit_done = unit_done & ~acked;
      for (int u = 0; u < N; u++) begin
        if (!unit_done[u] && $urandom_range(0, 1) == 1)
          set_unit(u, AW'($urandom_range(0, 63)), $urandom, IW'($urandom_range(0, 7)));
      end
      writeback_suppress = ($urandom_range(0, 4) == 0);
      init_clear         = ($urandom_range(0, 7) == 0);
    end
    unit_done = '0;
    writeback_suppress = 1'b0;
    init_clear = 1'b0;
    @(posedge clk); #1;

    // Reset while a commit is in flight.
    set_unit(1, 6'd33, 32'h5555_AAAA, 3'd5);
    @(negedge clk);
    check("pre_reset_ack", unit_ack, 4'b0010);
    @(posedge clk); #1 unit_done = '0;
    check("pre_reset_cv", commit_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("mid_reset_cv", commit_valid, 1'b0);
    check("mid_reset_addr", commit_phys_addr, 6'd0);
    @(posedge clk); #1 rst = 1'b0;
    set_unit(3, 6'd1, 32'h0000_0001, 3'd7);
    step(4'b1000, -1, 1'b1);
    step(4'b0000, 7, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
